// File: rtl/fft_loop_test_pkg.sv
// Shared types and RAM geometry for the FFT loop-test sample mover.
package fft_loop_test_pkg;

    localparam int RAM_ADDR_W       = 15;
    localparam int RAM_DATA_W       = 32;
    localparam int RAM_READ_LATENCY = 1;

    localparam logic MODE_CAPTURE  = 1'b1;
    localparam logic MODE_PLAYBACK = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PLAYBACK,
        DRAIN
    } state_t;

endpackage

// File: rtl/fft_loop_test_sc_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; head word is visible whenever not empty.
module fft_loop_test_sc_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_push  = push && (count_q != (PTR_W+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/fft_loop_test_frame_mover.sv
// Avalon-MM master moving sample frames between Avalon-ST streams and the on-chip sample RAM.
module fft_loop_test_frame_mover
    import fft_loop_test_pkg::*;
#(
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int READ_LATENCY = RAM_READ_LATENCY,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_base,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    input  logic [DATA_W-1:0]     snk_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic [DATA_W-1:0]     src_data,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic                  avm_clken,
    input  logic [DATA_W-1:0]     avm_readdata,
    output logic                  busy,
    output logic                  done
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       issued_q, issued_d;
    logic [LEN_W-1:0]       emitted_q, emitted_d;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                   done_q, done_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_head;
    logic [OCC_W-1:0]       occupancy;
    logic                   wr_issue;
    logic                   rd_issue;
    logic                   fifo_pop;
    logic                   last_issue;

    // Credit counts words already queued plus reads still in the RAM pipeline.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < READ_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(rd_pipe_q[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        emitted_d  = emitted_q;
        done_d     = 1'b0;
        wr_issue   = (state_q == CAPTURE) && snk_valid;
        rd_issue   = (state_q == PLAYBACK) && (issued_q != len_q)
                     && (occupancy < OCC_W'(FIFO_DEPTH));
        fifo_pop   = src_valid && src_ready;
        last_issue = ((issued_q + LEN_W'(1)) == len_q);

        rd_pipe_d[0] = rd_issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        if (fifo_pop) begin
            emitted_d = emitted_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_base;
                    len_d      = cmd_len;
                    issued_d   = '0;
                    emitted_d  = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_write == MODE_CAPTURE) begin
                        state_d = CAPTURE;
                    end else if (cmd_write == MODE_PLAYBACK) begin
                        state_d = PLAYBACK;
                    end
                end
            end
            CAPTURE: begin
                if (wr_issue) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    issued_d   = issued_q + LEN_W'(1);
                    if (last_issue) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            PLAYBACK: begin
                if (rd_issue) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    issued_d   = issued_q + LEN_W'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((occupancy == '0) && (emitted_q == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            emitted_q  <= '0;
            rd_pipe_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            emitted_q  <= emitted_d;
            rd_pipe_q  <= rd_pipe_d;
            done_q     <= done_d;
        end
    end

    fft_loop_test_sc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pipe_q[READ_LATENCY-1]),
        .push_data (avm_readdata),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready      = (state_q == IDLE);
    assign snk_ready      = (state_q == CAPTURE);
    assign src_valid      = !fifo_empty;
    assign src_data       = fifo_head;
    assign src_sop        = src_valid && (emitted_q == '0);
    assign src_eop        = src_valid && (emitted_q == (len_q - LEN_W'(1)));
    assign avm_address    = cur_addr_q;
    assign avm_byteenable = '1;
    assign avm_chipselect = wr_issue || rd_issue;
    assign avm_write      = wr_issue;
    assign avm_writedata  = snk_data;
    assign avm_clken      = !reset;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_fft_loop_test_frame_mover.sv
// Self-checking bench: RAM model, event monitor and a frame-level reference of expected RAM contents.
`timescale 1ns/1ps
module tb_fft_loop_test_frame_mover;
    import fft_loop_test_pkg::*;

    localparam int ADDR_W     = RAM_ADDR_W;
    localparam int DATA_W     = RAM_DATA_W;
    localparam int LEN_W      = ADDR_W + 1;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_write = 1'b0;
    logic [ADDR_W-1:0]   cmd_base = '0;
    logic [ADDR_W:0]     cmd_len = '0;
    logic                snk_valid = 1'b0;
    logic                snk_ready;
    logic [DATA_W-1:0]   snk_data = '0;
    logic                src_valid;
    logic                src_ready = 1'b0;
    logic [DATA_W-1:0]   src_data;
    logic                src_sop;
    logic                src_eop;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata = '0;
    logic                busy;
    logic                done;

    fft_loop_test_frame_mover #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (1),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .snk_data       (snk_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_data       (src_data),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // One-cycle read latency sample RAM.
    logic [DATA_W-1:0] ram [RAM_WORDS];
    always @(posedge clk) begin
        if (avm_chipselect && avm_clken) begin
            if (avm_write) ram[avm_address] <= avm_writedata;
            else           avm_readdata     <= ram[avm_address];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] acc_addr [$];
    bit                acc_wr   [$];
    logic [DATA_W-1:0] acc_data [$];
    int                acc_cyc  [$];
    logic [DATA_W-1:0] beat_data [$];
    bit                beat_sop  [$];
    bit                beat_eop  [$];
    int                beat_cyc  [$];
    int                done_cyc  [$];
    int                cmd_cyc   [$];
    int                rd_live = 0;
    int                bt_live = 0;
    int                max_outstanding = 0;
    int                stray_flags = 0;

    always @(negedge clk) begin
        if (reset) begin
            rd_live = 0;
            bt_live = 0;
        end else begin
            if (avm_chipselect) begin
                acc_addr.push_back(avm_address);
                acc_wr.push_back(avm_write);
                acc_data.push_back(avm_writedata);
                acc_cyc.push_back(cyc);
                if (!avm_write) rd_live++;
            end
            if (src_valid && src_ready) begin
                beat_data.push_back(src_data);
                beat_sop.push_back(src_sop);
                beat_eop.push_back(src_eop);
                beat_cyc.push_back(cyc);
                bt_live++;
            end
            if (rd_live - bt_live > max_outstanding) max_outstanding = rd_live - bt_live;
            if (!src_valid && (src_sop || src_eop)) stray_flags++;
            if (done) done_cyc.push_back(cyc);
            if (cmd_valid && cmd_ready) cmd_cyc.push_back(cyc);
        end
    end

    logic [DATA_W-1:0] ref_mem [RAM_WORDS];
    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendCommand(input bit is_write, input int base, input int len, output int accept_cyc);
        int n0;
        n0 = cmd_cyc.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = is_write;
        cmd_base  = base[ADDR_W-1:0];
        cmd_len   = len[LEN_W-1:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("cmd_accepted", 64'(cmd_cyc.size() - n0), 64'(1));
        accept_cyc = (cmd_cyc.size() > n0) ? cmd_cyc[n0] : 0;
    endtask

    // mode: 0 = held valid/ready, 1 = ready 1,0,0 pattern, 2 = random gaps
    task automatic applyStimulus(input bit is_write, input int base, input int len, input int mode, input bit ramp);
        int acc0, beat0, done0, c, limit, idx, addr;
        logic [DATA_W-1:0] cap_data [$];
        acc0  = acc_addr.size();
        beat0 = beat_data.size();
        done0 = done_cyc.size();
        limit = 8 * len + 40;
        for (int i = 0; i < len; i++) cap_data.push_back(ramp ? (32'hA0 + 32'(i)) : 32'($urandom()));
        sendCommand(is_write, base, len, c);
        if (is_write) begin
            idx = 0;
            snk_valid = (len > 0) && (mode == 0 || $urandom_range(0, 3) != 0);
            snk_data  = (len > 0) ? cap_data[0] : '0;
            for (int g = 0; g < limit && idx < len; g++) begin
                @(negedge clk);
                if (snk_valid && snk_ready) idx++;
                @(posedge clk); #1;
                snk_valid = (idx < len) && (mode == 0 || $urandom_range(0, 3) != 0);
                snk_data  = (idx < len) ? cap_data[idx] : '0;
            end
            snk_valid = 1'b0;
        end else begin
            for (int g = 0; g < limit && done_cyc.size() == done0; g++) begin
                src_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 3 == 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        src_ready = 1'b0;

        checkOutput("access_count", 64'(acc_addr.size() - acc0), 64'(len));
        for (int i = 0; i < len && acc0 + i < acc_addr.size(); i++) begin
            addr = (base + i) % RAM_WORDS;
            checkOutput("access_addr", 64'(acc_addr[acc0+i]), 64'(addr));
            checkOutput("access_kind", 64'(acc_wr[acc0+i]), 64'(is_write));
            if (is_write) checkOutput("write_data", 64'(acc_data[acc0+i]), 64'(cap_data[i]));
            if (mode == 0) checkOutput("access_cycle", 64'(acc_cyc[acc0+i]), 64'(c + 1 + i));
        end
        checkOutput("done_pulses", 64'(done_cyc.size() - done0), 64'(1));

        if (is_write) begin
            for (int i = 0; i < len; i++) ref_mem[(base + i) % RAM_WORDS] = cap_data[i];
            checkOutput("cap_no_beats", 64'(beat_data.size() - beat0), 64'(0));
            if (len > 0 && done_cyc.size() > done0 && acc_addr.size() > acc0)
                checkOutput("cap_done_cycle", 64'(done_cyc[done0]), 64'(acc_cyc[acc_addr.size()-1] + 1));
        end else begin
            checkOutput("beat_count", 64'(beat_data.size() - beat0), 64'(len));
            for (int i = 0; i < len && beat0 + i < beat_data.size(); i++) begin
                checkOutput("beat_data", 64'(beat_data[beat0+i]), 64'(ref_mem[(base + i) % RAM_WORDS]));
                checkOutput("beat_sop", 64'(beat_sop[beat0+i]), 64'(i == 0));
                checkOutput("beat_eop", 64'(beat_eop[beat0+i]), 64'(i == len - 1));
            end
            if (mode == 0 && len > 0 && beat_data.size() - beat0 == len) begin
                checkOutput("first_beat_cycle", 64'(beat_cyc[beat0]), 64'(c + 3));
                checkOutput("last_beat_cycle", 64'(beat_cyc[beat0+len-1]), 64'(c + len + 2));
            end
            if (len > 0 && done_cyc.size() > done0 && beat_data.size() > beat0)
                checkOutput("done_after_eop",
                            64'((done_cyc[done0] - beat_cyc[beat_data.size()-1]) inside {[1:3]}), 64'(1));
            checkOutput("fifo_bound", 64'(max_outstanding <= FIFO_DEPTH), 64'(1));
        end
        if (len == 0 && done_cyc.size() > done0)
            checkOutput("len0_done_cycle", 64'(done_cyc[done0]), 64'(c + 1));
    endtask

    initial begin
        int c, base, len, beat0, done0, acc_mark;

        #2;
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("rst_snk_ready", 64'(snk_ready), 64'(0));
        checkOutput("rst_src_valid", 64'(src_valid), 64'(0));
        checkOutput("rst_chipselect", 64'(avm_chipselect), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_clken", 64'(avm_clken), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("run_clken", 64'(avm_clken), 64'(1));
        checkOutput("run_byteenable", 64'(avm_byteenable), 64'(4'hF));

        applyStimulus(1'b1, 'h0010, 4, 0, 1'b1);
        applyStimulus(1'b0, 'h0010, 4, 0, 1'b0);
        applyStimulus(1'b1, 'h7FFE, 4, 0, 1'b0);
        applyStimulus(1'b0, 'h7FFE, 4, 0, 1'b0);
        applyStimulus(1'b1, 'h0200, 16, 2, 1'b0);
        applyStimulus(1'b0, 'h0200, 16, 1, 1'b0);
        applyStimulus(1'b1, 'h0300, 0, 0, 1'b0);
        applyStimulus(1'b0, 'h0300, 0, 0, 1'b0);
        applyStimulus(1'b1, 'h0400, 1, 0, 1'b0);
        applyStimulus(1'b0, 'h0400, 1, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            base = int'($urandom_range(0, RAM_WORDS - 1));
            len  = int'($urandom_range(1, 40));
            applyStimulus(1'b1, base, len, 2, 1'b0);
            applyStimulus(1'b0, base, len, int'($urandom_range(0, 2)), 1'b0);
        end

        // Abort a long playback during its fifth beat.
        base = 'h1000;
        applyStimulus(1'b1, base, 32, 0, 1'b0);
        beat0 = beat_data.size();
        done0 = done_cyc.size();
        sendCommand(1'b0, base, 32, c);
        src_ready = 1'b1;
        for (int g = 0; g < 200 && beat_data.size() - beat0 < 4; g++) @(negedge clk);
        @(posedge clk); #1;
        checkOutput("abort_beat5_valid", 64'(src_valid), 64'(1));
        checkOutput("abort_busy_cmd_ready", 64'(cmd_ready), 64'(0));
        reset = 1'b1;
        #1;
        checkOutput("abort_src_valid", 64'(src_valid), 64'(0));
        checkOutput("abort_sop_eop", 64'({src_sop, src_eop}), 64'(0));
        checkOutput("abort_chipselect", 64'({avm_chipselect, avm_write}), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("abort_clken", 64'(avm_clken), 64'(0));
        acc_mark = acc_addr.size();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        src_ready = 1'b0;
        #1;
        checkOutput("release_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_no_access", 64'(acc_addr.size() - acc_mark), 64'(0));
        checkOutput("abort_no_done", 64'(done_cyc.size() - done0), 64'(0));
        applyStimulus(1'b0, base, 32, 2, 1'b0);

        checkOutput("sop_eop_qualified", 64'(stray_flags), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_loop_test_frame_mover.md
Name: fft_loop_test_frame_mover

Overview:
- Avalon-MM master that drives the 32-bit single-port on-chip sample RAM (15-bit word address, byteenable, fixed read latency, no waitrequest).
- Capture mode: writes a frame from an Avalon-ST sink into RAM.
- Playback mode: reads a frame from RAM and emits it on an Avalon-ST source with sop/eop.
- Sits between the FFT loop-test sample path and the on-chip memory slave port.

Parameters:
- ADDR_W, 15, RAM word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from read address to valid avm_readdata.
- FIFO_DEPTH, 4, playback output FIFO depth (power of 2, >= READ_LATENCY+2).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high only in IDLE.
- cmd_write, in, 1, 1=capture, 0=playback.
- cmd_base, in, ADDR_W, start word address.
- cmd_len, in, ADDR_W+1, frame length in words (0..2^ADDR_W).
- snk_valid, in, 1; snk_ready, out, 1; snk_data, in, DATA_W: capture stream.
- src_valid, out, 1; src_ready, in, 1; src_data, out, DATA_W; src_sop, out, 1; src_eop, out, 1: playback stream.
- avm_address, out, ADDR_W; avm_byteenable, out, DATA_W/8; avm_chipselect, out, 1; avm_write, out, 1; avm_writedata, out, DATA_W; avm_clken, out, 1: RAM master signals.
- avm_readdata, in, DATA_W: RAM read data.
- busy, out, 1: state != IDLE.
- done, out, 1: one-cycle pulse at frame completion.

Behaviour:
- Reset values: state IDLE; all counters, FIFO pointers and the in-flight pipeline cleared.
- Outputs in reset: cmd_ready=1, snk_ready=0, src_valid/sop/eop=0, avm_chipselect=0, avm_write=0, busy=0, done=0, avm_clken=0.
- Outside reset, avm_clken=1 and avm_byteenable is all ones.
- States: IDLE, CAPTURE, PLAYBACK, DRAIN.
- IDLE: on cmd_valid&cmd_ready, latch base, len and mode; cur_addr=base, issued=0, emitted=0.
  - cmd_len=0: stay IDLE and pulse done the next cycle.
  - Otherwise go to CAPTURE or PLAYBACK the next cycle.
- CAPTURE:
  - snk_ready=1.
  - On snk_valid: avm_chipselect=avm_write=1 in the same cycle (combinational), avm_writedata=snk_data, avm_address=cur_addr.
  - Then cur_addr+1 mod 2^ADDR_W and issued+1.
  - After the len-th write, go to IDLE and pulse done in the following cycle. snk_ready is low from that cycle onward.
- PLAYBACK:
  - Issue a read (chipselect=1, write=0, address=cur_addr) when issued<len and fifo_count+inflight < FIFO_DEPTH.
  - On issue, cur_addr increments with wrap.
  - A valid bit travels through a READ_LATENCY-deep shift register. When it exits, avm_readdata is pushed into the FIFO.
  - After the last issue, go to DRAIN.
- DRAIN: when inflight=0, the FIFO is empty and the last word has been handshaken, go to IDLE and pulse done.
- FIFO is show-ahead: src_valid = !empty; src_data = head.
- src_sop=1 when emitted=0; src_eop=1 when emitted=len-1, both qualified by src_valid.
- emitted increments on src_valid&src_ready.
- Latency (READ_LATENCY=1):
  - Command accepted in cycle C; first read issued in C+1.
  - First src_valid in C+3.
  - With src_ready held high, sustained throughput is 1 word/cycle; the last eop beat is at C+len+2.
- Backpressure: the credit rule guarantees no FIFO overflow and no lost readdata. Reads stall while credit is exhausted.
- Address wrap: 0x7FFF+1 -> 0x0000; a frame may straddle it.
- cmd_len=2^ADDR_W is legal and covers the whole RAM once.
- Simultaneous FIFO push and pop in one cycle leaves the count unchanged.
- Asynchronous reset mid-operation aborts the frame: no further RAM access, FIFO flushed, no done pulse.
- Commands presented while busy are ignored (cmd_ready=0).

Decomposition:
- Shared package fft_loop_test_pkg:
  - state enum (IDLE, CAPTURE, PLAYBACK, DRAIN);
  - RAM_ADDR_W=15, RAM_DATA_W=32, RAM_READ_LATENCY=1;
  - MODE_CAPTURE/MODE_PLAYBACK constants.
- One sub-module, fft_loop_test_sc_fifo: a single-clock show-ahead FIFO with count output, async active-high reset, and parameters DATA_W and DEPTH.

Test Plan:
- Capture base=0x0010, len=4, data 0xA0..0xA3 with snk_valid held high -> writes to 0x10..0x13 on consecutive cycles; done pulses once.
- Then playback base=0x0010, len=4 with src_ready=1 -> src_data A0,A1,A2,A3 on cycles C+3..C+6; sop on A0, eop on A3; done follows.
- Wrap: playback base=0x7FFE, len=4 -> avm_address 0x7FFE, 0x7FFF, 0x0000, 0x0001; data returned in order.
- Backpressure: playback len=16 with src_ready toggling 1,0,0,1,... -> all 16 words emitted in order with no duplicates; the FIFO never exceeds 4 entries; reads stall while credit is zero.
- Edge lengths:
  - len=0 -> no RAM access, done one cycle after accept;
  - len=1 -> a single beat with sop=eop=1.
- Reset asserted during the 5th beat of a len=32 playback -> all outputs take reset values immediately; cmd_ready=1 after release; no done pulse; the next command runs correctly.
